// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: arm/trigger/N-word capture sequencer feeding the ADC FIFO; ADC_CAP_DECIM_EN enables decimation
module adc_capture_ctrl #(
  parameter int DATA_W  = 16,
  parameter int COUNT_W = 24,
  parameter int DECIM_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     trig_mode,
  input  logic signed [DATA_W-1:0] trig_threshold,
  input  logic [COUNT_W-1:0]       sample_count,
  input  logic [DECIM_W-1:0]       decim_factor,
  input  logic signed [DATA_W-1:0] adc_data_1,
  input  logic signed [DATA_W-1:0] adc_data_2,
  input  logic                     data_valid,
  input  logic                     rdy,
  input  logic                     mmcm_locked,
  input  logic                     fifo_busy,
  input  logic                     fifo_prog_full,
  output logic [2*DATA_W-1:0]      fifo_din,
  output logic                     fifo_wr_en,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow,
  output logic [COUNT_W-1:0]       samples_written
);
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
  state_t state;
  logic signed [DATA_W-1:0] thr_l, prev;
  logic prev_v, mode_l, ok, hit, keep, emit, last;
  logic [COUNT_W-1:0] count_l, sw_inc;
`ifdef ADC_CAP_DECIM_EN
  logic [DECIM_W-1:0] decim_l, dcnt;
  assign keep = dcnt == '0;
`else
  logic unused_decim;
  assign unused_decim = ^decim_factor;
  assign keep = 1'b1;
`endif
  assign ok     = mmcm_locked & rdy & data_valid & ~fifo_busy;
  assign hit    = ~mode_l | (prev_v & (prev < thr_l) & (adc_data_1 >= thr_l));
  assign emit   = ok & ((state == ARMED) ? hit : ((state == CAPTURE) & keep));
  assign sw_inc = samples_written + COUNT_W'(1);
  assign last   = (count_l != '0) & (sw_inc == count_l);
  // Capture FSM: arming, trigger search, registered FIFO writes and status
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      fifo_wr_en      <= 1'b0;
      fifo_din        <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      overflow        <= 1'b0;
      samples_written <= '0;
      prev_v          <= 1'b0;
      prev            <= '0;
      thr_l           <= '0;
      mode_l          <= 1'b0;
      count_l         <= '0;
`ifdef ADC_CAP_DECIM_EN
      decim_l         <= '0;
      dcnt            <= '0;
`endif
    end else begin
      fifo_wr_en <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: if (start) begin
            state           <= ARMED;
            busy            <= 1'b1;
            done            <= 1'b0;
            overflow        <= 1'b0;
            samples_written <= '0;
            prev_v          <= 1'b0;
            count_l         <= sample_count;
            mode_l          <= trig_mode;
            thr_l           <= trig_threshold;
`ifdef ADC_CAP_DECIM_EN
            decim_l         <= decim_factor;
            dcnt            <= '0;
`endif
          end
          ARMED: if (ok) begin
            if (hit) state <= CAPTURE;
            else begin
              prev   <= adc_data_1;
              prev_v <= 1'b1;
            end
          end
          default: ;
        endcase
`ifdef ADC_CAP_DECIM_EN
        if (emit) dcnt <= decim_l;
        else if (ok && state == CAPTURE) dcnt <= dcnt - DECIM_W'(1);
`endif
        if (emit) begin
          if (fifo_prog_full) overflow <= 1'b1;
          else begin
            fifo_wr_en      <= 1'b1;
            fifo_din        <= {adc_data_1, adc_data_2};
            samples_written <= &samples_written ? samples_written : sw_inc;
            if (last) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl: directed stimulus with a per-cycle reference model and literal spot checks
module tb_adc_capture_ctrl;
  logic clk = 0, reset = 1, start = 0, abort = 0, trig_mode = 0;
  logic [15:0] trig_threshold = 0, adc_data_1 = 0, adc_data_2 = 0;
  logic [23:0] sample_count = 0;
  logic [7:0] decim_factor = 0;
  logic data_valid = 1, rdy = 1, mmcm_locked = 1, fifo_busy = 0, fifo_prog_full = 0;
  logic [31:0] fifo_din;
  logic fifo_wr_en, busy, done, overflow;
  logic [23:0] samples_written;
  int checks = 0, failures = 0;
  logic chk_en = 0;
  logic [15:0] r1 = 0;
  int step = 1;
  logic toggle_dv = 0;
  logic [31:0] cap[$];
  int m_phase = 0;
  logic m_wr = 0, m_ovf = 0, m_mode = 0, m_prev_ok = 0;
  logic [31:0] m_din = 0;
  logic [23:0] m_cnt = 0, m_target = 0;
  logic [15:0] m_thr = 0, m_prev = 0;
  int m_skip = 0, m_decim = 0;

  adc_capture_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .trig_mode(trig_mode),
    .trig_threshold(trig_threshold), .sample_count(sample_count), .decim_factor(decim_factor),
    .adc_data_1(adc_data_1), .adc_data_2(adc_data_2), .data_valid(data_valid), .rdy(rdy),
    .mmcm_locked(mmcm_locked), .fifo_busy(fifo_busy), .fifo_prog_full(fifo_prog_full),
    .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .busy(busy), .done(done),
    .overflow(overflow), .samples_written(samples_written)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Phases: 0 idle, 1 waiting for trigger, 2 capturing, 3 finished.
  task automatic model_step();
    logic okv, emit;
    emit = 0;
    m_wr = 0;
    okv = mmcm_locked & rdy & data_valid & ~fifo_busy;
    if (reset) begin
      m_phase = 0; m_ovf = 0; m_cnt = 0; m_din = 0; m_prev_ok = 0;
    end else if (abort) m_phase = 0;
    else begin
      if ((m_phase == 0 || m_phase == 3) && start) begin
        m_phase = 1; m_ovf = 0; m_cnt = 0; m_prev_ok = 0; m_skip = 0;
        m_target = sample_count; m_mode = trig_mode; m_thr = trig_threshold;
`ifdef ADC_CAP_DECIM_EN
        m_decim = int'(decim_factor);
`endif
      end else if (m_phase == 1 && okv) begin
        if (!m_mode || (m_prev_ok && $signed(m_prev) < $signed(m_thr) && $signed(adc_data_1) >= $signed(m_thr))) begin
          emit = 1; m_phase = 2;
        end else begin
          m_prev = adc_data_1; m_prev_ok = 1;
        end
      end else if (m_phase == 2 && okv) begin
        if (m_skip > 0) m_skip--;
        else emit = 1;
      end
      if (emit) begin
        m_skip = m_decim;
        if (fifo_prog_full) m_ovf = 1;
        else begin
          m_wr = 1;
          m_din = {adc_data_1, adc_data_2};
          if (m_cnt != 24'hFFFFFF) m_cnt = m_cnt + 24'd1;
          if (m_target != 0 && m_cnt == m_target) m_phase = 3;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("wr_en", fifo_wr_en, m_wr);
      if (m_wr) chk("din", fifo_din, m_din);
      chk("busy", busy, m_phase == 1 || m_phase == 2);
      chk("done", done, m_phase == 3);
      chk("overflow", overflow, m_ovf);
      chk("samples_written", samples_written, m_cnt);
    end
    if (fifo_wr_en === 1'b1) cap.push_back(fifo_din);
    model_step();
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      r1 = r1 + 16'(step);
      adc_data_1 = r1;
      adc_data_2 = r1 + 16'h1000;
      if (toggle_dv) data_valid = ~data_valid;
    end
  endtask

  task automatic setr(input logic [15:0] v);
    r1 = v;
    adc_data_1 = v;
    adc_data_2 = v + 16'h1000;
  endtask

  task automatic arm(input logic mode, input logic [23:0] cnt, input logic [15:0] thr, input logic [7:0] dec);
    cap.delete();
    trig_mode = mode; sample_count = cnt; trig_threshold = thr; decim_factor = dec;
    start = 1;
    cyc();
    start = 0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k;
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      cyc();
      k++;
    end
    chk(name, done, 1'b1);
  endtask

  initial begin
    cyc(2);
    chk_en = 1;
    chk("rst_busy", busy, 0);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_count", samples_written, 0);
    chk("rst_din", fifo_din, 0);
    reset = 0;
    cyc(2);
    // immediate capture of 8 ramp words
    step = 1;
    setr(16'h0010);
    arm(0, 24'd8, 16'h0, 8'd0);
    wait_done(20, "t1_done_timeout");
    cyc();
    chk("t1_count", samples_written, 24'd8);
    chk("t1_busy", busy, 0);
    chk("t1_words", cap.size(), 8);
    chk("t1_first", cap[0], 32'h00111011);
    chk("t1_last", cap[7], 32'h00181018);
    // threshold rising crossing
    step = 8;
    setr(16'h00E8);
    arm(1, 24'd4, 16'h0100, 8'd0);
    wait_done(20, "t2_done_timeout");
    cyc();
    chk("t2_words", cap.size(), 4);
    chk("t2_first", cap[0][31:16], 16'h0100);
    chk("t2_last", cap[3][31:16], 16'h0118);
    // descending input never crosses upward
    step = -8;
    setr(16'h0208);
    arm(1, 24'd4, 16'h0100, 8'd0);
    cyc(20);
    chk("t2b_busy", busy, 1);
    chk("t2b_count", samples_written, 0);
    chk("t2b_words", cap.size(), 0);
    abort = 1;
    cyc();
    abort = 0;
    chk("t2b_abort_busy", busy, 0);
    chk("t2b_abort_done", done, 0);
    // prog_full drops accepted samples 5..7
    step = 1;
    setr(16'h0300);
    arm(0, 24'd16, 16'h0, 8'd0);
    cyc(4);
    fifo_prog_full = 1;
    cyc(3);
    fifo_prog_full = 0;
    wait_done(30, "t3_done_timeout");
    cyc();
    chk("t3_overflow", overflow, 1);
    chk("t3_count", samples_written, 24'd16);
    chk("t3_words", cap.size(), 16);
    chk("t3_after_gap", cap[4][31:16], 16'h0308);
    cyc(3);
    chk("t3_ovf_hold", overflow, 1);
    chk("t3_done_hold", done, 1);
    arm(0, 24'd4, 16'h0, 8'd0);
    chk("t3_ovf_clear", overflow, 0);
    chk("t3_rearm_busy", busy, 1);
    wait_done(10, "t3b_done_timeout");
    cyc();
    // gated data_valid and FIFO reset-busy window
    setr(16'h0400);
    toggle_dv = 1;
    arm(0, 24'd4, 16'h0, 8'd0);
    cyc(2);
    fifo_busy = 1;
    cyc(4);
    fifo_busy = 0;
    wait_done(30, "t4_done_timeout");
    cyc();
    toggle_dv = 0;
    data_valid = 1;
    chk("t4_words", cap.size(), 4);
    chk("t4_count", samples_written, 24'd4);
    chk("t4_w0", cap[0][31:16], 16'h0402);
    chk("t4_w1", cap[1][31:16], 16'h0408);
    chk("t4_w3", cap[3][31:16], 16'h040C);
    // continuous capture then abort
    setr(16'h0500);
    arm(0, 24'd0, 16'h0, 8'd0);
    cyc(10);
    abort = 1;
    cyc();
    abort = 0;
    chk("t5_count", samples_written, 24'd10);
    chk("t5_done", done, 0);
    chk("t5_busy", busy, 0);
    cyc();
    chk("t5_words", cap.size(), 10);
    start = 1;
    abort = 1;
    cyc();
    start = 0;
    abort = 0;
    cyc();
    chk("t5_abort_wins", busy, 0);
    chk("t5_count_hold", samples_written, 24'd10);
`ifdef ADC_CAP_DECIM_EN
    // decimate by 3 from a ramp starting at 0
    setr(16'hFFFF);
    arm(0, 24'd4, 16'h0, 8'd2);
    wait_done(30, "t6_done_timeout");
    cyc();
    chk("t6_words", cap.size(), 4);
    chk("t6_w0", cap[0][31:16], 16'd0);
    chk("t6_w1", cap[1][31:16], 16'd3);
    chk("t6_w2", cap[2][31:16], 16'd6);
    chk("t6_w3", cap[3][31:16], 16'd9);
`endif
    // reset in the middle of a continuous capture
    setr(16'h0700);
    arm(0, 24'd0, 16'h0, 8'd0);
    cyc(2);
    fifo_prog_full = 1;
    cyc();
    fifo_prog_full = 0;
    cyc(2);
    chk("t7_writing", fifo_wr_en, 1);
    chk("t7_ovf_set", overflow, 1);
    reset = 1;
    cyc();
    chk("t7_wr_en", fifo_wr_en, 0);
    chk("t7_busy", busy, 0);
    chk("t7_done", done, 0);
    chk("t7_ovf", overflow, 0);
    chk("t7_count", samples_written, 0);
    chk("t7_din", fifo_din, 0);
    reset = 0;
    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
- Capture sequencer in the ADC data-clock domain, between the SYZYGY ADC receiver outputs and the async capture FIFO write port.
- On an arm pulse it waits for an immediate or threshold trigger, then writes exactly N packed two-channel sample words into the FIFO.
- It respects FIFO back-pressure and reset-busy, and reports done, overflow and a written-word count for host readout.

Parameters:
DATA_W, 16, per-channel sample width
COUNT_W, 24, width of sample_count and samples_written
DECIM_W, 8, width of decim_factor (used only with ADC_CAP_DECIM_EN)

Ports:
clk  in  1  ADC data clock (adc_data_clk); all logic on rising edge
reset  in  1  synchronous, active-high; returns block to IDLE
start  in  1  single-cycle arm pulse (trigger-in endpoint, already in clk domain)
abort  in  1  single-cycle pulse; ends any capture
trig_mode  in  1  0 = immediate, 1 = channel-1 threshold rising crossing
trig_threshold  in  DATA_W  signed threshold for channel 1
sample_count  in  COUNT_W  words to capture; 0 = continuous until abort
decim_factor  in  DECIM_W  keep 1 of (decim_factor+1) samples; ignored without macro
adc_data_1  in  DATA_W  channel 1 sample, signed
adc_data_2  in  DATA_W  channel 2 sample, signed
data_valid  in  1  receiver bitslip aligned, sample valid this cycle
rdy  in  1  IDELAY/SERDES ready
mmcm_locked  in  1  clock wizard locked
fifo_busy  in  1  FIFO reset sequence active, synchronised to clk
fifo_prog_full  in  1  FIFO programmable-full
fifo_din  out  2*DATA_W  {adc_data_1, adc_data_2}
fifo_wr_en  out  1  FIFO write strobe
busy  out  1  high in ARMED or CAPTURE
done  out  1  high in DONE
overflow  out  1  sticky; a sample was dropped for prog_full
samples_written  out  COUNT_W  words written since last start

Behaviour:
- Reset: state IDLE; fifo_wr_en, busy, done, overflow = 0; samples_written = 0; fifo_din = 0; prev-sample-valid flag cleared.
- ok = mmcm_locked & rdy & data_valid & ~fifo_busy. A sample is "accepted" only in a cycle with ok = 1.
- States: IDLE, ARMED, CAPTURE, DONE.
- IDLE or DONE + start: go to ARMED; clear overflow, samples_written, done and the prev flag; latch sample_count, trig_mode, trig_threshold and decim_factor.
- ARMED, trig_mode = 0: the first accepted sample transitions to CAPTURE and is itself written.
- ARMED, trig_mode = 1:
  - The first accepted sample only loads prev and sets the prev flag.
  - Trigger fires when prev flag is set, signed prev < thr and signed cur >= thr.
  - The triggering sample is the first word written; otherwise cur becomes prev.
- CAPTURE, accepted sample with fifo_prog_full = 0: register fifo_din, pulse fifo_wr_en next cycle, increment samples_written.
- CAPTURE, accepted sample with fifo_prog_full = 1: drop the word, no wr_en, set overflow (sticky), no count increment.
- Terminal count: when samples_written reaches latched count (nonzero), go to DONE in the same cycle as the final write registration. Exactly N wr_en pulses result.
- Count 0: capture continues until abort. samples_written saturates at all-ones; writes continue.
- Latency: accepted sample to fifo_wr_en/fifo_din = 1 cycle. fifo_wr_en is never high for two writes of the same sample.
- abort, in any state other than IDLE: go to IDLE next cycle; done not set; the write already registered still completes.
- abort and start in the same cycle: abort wins.
- start while busy: ignored.
- reset mid-capture: immediate IDLE; a pending fifo_wr_en is forced low.
- busy = ARMED | CAPTURE.
- overflow and samples_written hold through DONE/IDLE until the next start or reset.

Optional Feature:
- Macro ADC_CAP_DECIM_EN.
- Defined: in CAPTURE a DECIM_W counter skips decim_factor accepted samples between kept samples. The trigger sample is always kept. Only kept samples are checked against prog_full or counted. Counter clears on start.
- Undefined: every accepted sample is kept; decim_factor is ignored; no counter logic is synthesised.

Test Plan:
- Immediate mode, count = 8, ok held 1, prog_full = 0, start → wr_en on the 8 cycles following the first accepted sample; samples_written = 8; done = 1; fifo_din matches ramp inputs delayed 1 cycle.
- Threshold mode, thr = 0x0100, ch1 ramp 0x00F0, 0x00F8, 0x0100 → first word ch1 = 0x0100. Then repeat with ch1 starting at 0x0200 and descending → no trigger, busy stays 1.
- Count = 16, prog_full asserted on accepted samples 5–7 → 3 samples dropped, overflow = 1; done after 16 actual writes; overflow holds until the next start.
- data_valid toggled every other cycle and fifo_busy high for 4 cycles mid-capture → only ok cycles write; count = 4 completes with exactly 4 wr_en pulses.
- Count = 0 continuous, abort after 10 writes → IDLE, done = 0, samples_written = 10. Then abort+start in the same cycle → stays IDLE.
- With ADC_CAP_DECIM_EN, decim_factor = 2, count = 4, ramp 0..20 → written ch1 = 0, 3, 6, 9; reset asserted mid-run → wr_en low the next cycle, all outputs at reset values.
